// File: rtl/cpu_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer for the MIPS-subset datapath.
// Optional retired-instruction counter: define CPU_SEQ_PERF_CNT_EN.
module cpu_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic [5:0]  op_code,
  input  logic [5:0]  func,
  input  logic        alu_zero,
  input  logic        mem_ready,
  output logic        pc_we,
  output logic [1:0]  pc_src,
  output logic        ir_we,
  output logic        reg_we,
  output logic [1:0]  reg_dst,
  output logic [1:0]  wb_sel,
  output logic        alu_src_b,
  output logic [2:0]  alu_op,
  output logic        mem_re,
  output logic        mem_we,
  output logic        retire,
  output logic        halted,
  output logic [31:0] instr_count
);

  localparam int unsigned OP_W  = 6;
  localparam int unsigned CNT_W = 32;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_J     = 6'h02;
  localparam logic [OP_W-1:0] OP_JAL   = 6'h03;
  localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OP_W-1:0] OP_XORI  = 6'h0E;
  localparam logic [OP_W-1:0] OP_LW    = 6'h23;
  localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

  localparam logic [OP_W-1:0] FN_JR    = 6'h08;
  localparam logic [OP_W-1:0] FN_ADD   = 6'h20;
  localparam logic [OP_W-1:0] FN_SUB   = 6'h22;
  localparam logic [OP_W-1:0] FN_SLT   = 6'h2A;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_XOR = 3'd2;
  localparam logic [2:0] ALU_SLT = 3'd3;

  localparam logic [1:0] PC_SEQ    = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;
  localparam logic [1:0] PC_REG    = 2'd3;

  localparam logic [1:0] DST_RT  = 2'd0;
  localparam logic [1:0] DST_RD  = 2'd1;
  localparam logic [1:0] DST_R31 = 2'd2;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  state_t r_state;
  state_t w_next_state;

  // Instruction classification from the IR fields
  logic w_is_r, w_is_add, w_is_sub, w_is_slt, w_is_jr, w_is_alu_r;
  logic w_is_j, w_is_jal, w_is_bne, w_is_addi, w_is_xori, w_is_lw, w_is_sw;
  logic w_is_legal, w_is_imm;
  logic [2:0] w_exec_alu_op;

  assign w_is_r     = (op_code == OP_RTYPE);
  assign w_is_add   = w_is_r && (func == FN_ADD);
  assign w_is_sub   = w_is_r && (func == FN_SUB);
  assign w_is_slt   = w_is_r && (func == FN_SLT);
  assign w_is_jr    = w_is_r && (func == FN_JR);
  assign w_is_alu_r = w_is_add || w_is_sub || w_is_slt;
  assign w_is_j     = (op_code == OP_J);
  assign w_is_jal   = (op_code == OP_JAL);
  assign w_is_bne   = (op_code == OP_BNE);
  assign w_is_addi  = (op_code == OP_ADDI);
  assign w_is_xori  = (op_code == OP_XORI);
  assign w_is_lw    = (op_code == OP_LW);
  assign w_is_sw    = (op_code == OP_SW);
  assign w_is_imm   = w_is_addi || w_is_xori || w_is_lw || w_is_sw;
  assign w_is_legal = w_is_alu_r || w_is_jr || w_is_j || w_is_jal || w_is_bne
                   || w_is_addi || w_is_xori || w_is_lw || w_is_sw;

  always_comb begin
    w_exec_alu_op = ALU_ADD;
    if (w_is_sub || w_is_bne) w_exec_alu_op = ALU_SUB;
    else if (w_is_slt)        w_exec_alu_op = ALU_SLT;
    else if (w_is_xori)       w_exec_alu_op = ALU_XOR;
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:   if (run) w_next_state = S_FETCH;
      S_FETCH:  w_next_state = S_DECODE;
      S_DECODE: begin
        if (!w_is_legal)                         w_next_state = S_HALT;
        else if (w_is_j || w_is_jal || w_is_jr)  w_next_state = S_FETCH;
        else                                     w_next_state = S_EXEC;
      end
      S_EXEC: begin
        if (w_is_lw || w_is_sw) w_next_state = S_MEM;
        else if (w_is_bne)      w_next_state = S_FETCH;
        else                    w_next_state = S_WB;
      end
      S_MEM:    if (mem_ready) w_next_state = w_is_lw ? S_WB : S_FETCH;
      S_WB:     w_next_state = S_FETCH;
      S_HALT:   w_next_state = S_HALT;
      default:  w_next_state = S_IDLE;
    endcase
  end

  // Output decode; reset forces every output low in the same cycle
  always_comb begin
    pc_we     = 1'b0;
    pc_src    = PC_SEQ;
    ir_we     = 1'b0;
    reg_we    = 1'b0;
    reg_dst   = DST_RT;
    wb_sel    = WB_ALU;
    alu_src_b = 1'b0;
    alu_op    = ALU_ADD;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    retire    = 1'b0;
    halted    = 1'b0;
    if (!reset) begin
      case (r_state)
        S_FETCH: begin
          ir_we = 1'b1;
          pc_we = 1'b1;
        end
        S_DECODE: begin
          if (w_is_j || w_is_jal) begin
            pc_we  = 1'b1;
            pc_src = PC_JUMP;
            retire = 1'b1;
          end
          if (w_is_jal) begin
            reg_we  = 1'b1;
            reg_dst = DST_R31;
            wb_sel  = WB_PC4;
          end
          if (w_is_jr) begin
            pc_we  = 1'b1;
            pc_src = PC_REG;
            retire = 1'b1;
          end
        end
        S_EXEC: begin
          alu_op    = w_exec_alu_op;
          alu_src_b = w_is_imm;
          if (w_is_bne) begin
            retire = 1'b1;
            if (!alu_zero) begin
              pc_we  = 1'b1;
              pc_src = PC_BRANCH;
            end
          end
        end
        S_MEM: begin
          alu_op    = ALU_ADD;
          alu_src_b = 1'b1;
          mem_re    = w_is_lw;
          mem_we    = w_is_sw;
          retire    = w_is_sw && mem_ready;
        end
        S_WB: begin
          reg_we  = 1'b1;
          retire  = 1'b1;
          reg_dst = w_is_alu_r ? DST_RD : DST_RT;
          wb_sel  = w_is_lw ? WB_MEM : WB_ALU;
        end
        S_HALT:  halted = 1'b1;
        default: ;
      endcase
    end
  end

`ifdef CPU_SEQ_PERF_CNT_EN
  logic [CNT_W-1:0] r_instr_count;

  // Retired-instruction counter, wraps naturally at 2^32
  always_ff @(posedge clk) begin
    if (reset)       r_instr_count <= '0;
    else if (retire) r_instr_count <= r_instr_count + CNT_W'(1);
  end

  assign instr_count = reset ? '0 : r_instr_count;
`else
  assign instr_count = '0;
`endif

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: per-instruction expected control traces
// compared every cycle, plus directed cycle-count and counter checks.
module tb_cpu_sequencer;

  typedef struct packed {
    logic       pc_we;
    logic [1:0] pc_src;
    logic       ir_we;
    logic       reg_we;
    logic [1:0] reg_dst;
    logic [1:0] wb_sel;
    logic       alu_src_b;
    logic [2:0] alu_op;
    logic       mem_re;
    logic       mem_we;
    logic       retire;
    logic       halted;
  } ctl_t;

  typedef enum int {K_ALU_R, K_ADDI, K_XORI, K_LW, K_SW, K_J, K_JAL, K_JR, K_BNE, K_ILL} kind_t;

  logic        clk, reset, run, alu_zero, mem_ready;
  logic [5:0]  op_code, func;
  logic        pc_we, ir_we, reg_we, alu_src_b, mem_re, mem_we, retire, halted;
  logic [1:0]  pc_src, reg_dst, wb_sel;
  logic [2:0]  alu_op;
  logic [31:0] instr_count;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] m_cnt = '0;
  int          t_cyc, t_retire, t_mem_re;

  cpu_sequencer dut (
    .clk(clk), .reset(reset), .run(run), .op_code(op_code), .func(func),
    .alu_zero(alu_zero), .mem_ready(mem_ready), .pc_we(pc_we), .pc_src(pc_src),
    .ir_we(ir_we), .reg_we(reg_we), .reg_dst(reg_dst), .wb_sel(wb_sel),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .mem_re(mem_re), .mem_we(mem_we),
    .retire(retire), .halted(halted), .instr_count(instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic ctl_t actual_ctl();
    ctl_t a;
    a.pc_we = pc_we; a.pc_src = pc_src; a.ir_we = ir_we; a.reg_we = reg_we;
    a.reg_dst = reg_dst; a.wb_sel = wb_sel; a.alu_src_b = alu_src_b;
    a.alu_op = alu_op; a.mem_re = mem_re; a.mem_we = mem_we;
    a.retire = retire; a.halted = halted;
    return a;
  endfunction

  function automatic kind_t kind_of(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'h00: begin
        if (fn == 6'h20 || fn == 6'h22 || fn == 6'h2A) return K_ALU_R;
        if (fn == 6'h08) return K_JR;
        return K_ILL;
      end
      6'h02: return K_J;
      6'h03: return K_JAL;
      6'h05: return K_BNE;
      6'h08: return K_ADDI;
      6'h0E: return K_XORI;
      6'h23: return K_LW;
      6'h2B: return K_SW;
      default: return K_ILL;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // One clock from a negedge: drive, settle, compare, advance the counter model
  task automatic step(input ctl_t e, input logic rst, input logic rn,
                      input logic [5:0] op, input logic [5:0] fn,
                      input logic z, input logic rdy);
    ctl_t a;
    logic [31:0] exp_cnt;
    reset = rst; run = rn; op_code = op; func = fn; alu_zero = z; mem_ready = rdy;
    #2;
    a = actual_ctl();
`ifdef CPU_SEQ_PERF_CNT_EN
    exp_cnt = rst ? 32'd0 : m_cnt;
`else
    exp_cnt = 32'd0;
`endif
    check("ctl_outputs", 32'(a), 32'(e));
    check("instr_count", instr_count, exp_cnt);
    t_cyc++;
    if (a.retire) t_retire++;
    if (a.mem_re) t_mem_re++;
    if (rst) m_cnt = '0;
    else if (e.retire) m_cnt = m_cnt + 32'd1;
    @(negedge clk);
  endtask

  function automatic logic r1();
    return 1'($urandom);
  endfunction

  function automatic logic [5:0] r6();
    return 6'($urandom);
  endfunction

  task automatic do_reset();
    step('0, 1'b1, r1(), r6(), r6(), r1(), r1());
  endtask

  // Idle for n cycles with run low, then one cycle with run high
  task automatic idle_then_run(input int n);
    for (int i = 0; i < n; i++) step('0, 1'b0, 1'b0, r6(), r6(), r1(), r1());
    step('0, 1'b0, 1'b1, r6(), r6(), r1(), r1());
  endtask

  // Expected control trace of one instruction; abort >= 0 resets in that MEM cycle
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input int waits, input int abort, output int cycles);
    ctl_t  e;
    kind_t k;
    k = kind_of(op, fn);
    t_cyc = 0; t_retire = 0; t_mem_re = 0;
    cycles = 0;

    e = '0; e.ir_we = 1'b1; e.pc_we = 1'b1;
    step(e, 1'b0, r1(), r6(), r6(), r1(), r1());

    e = '0;
    if (k == K_J || k == K_JAL) begin e.pc_we = 1'b1; e.pc_src = 2'd2; e.retire = 1'b1; end
    if (k == K_JAL) begin e.reg_we = 1'b1; e.reg_dst = 2'd2; e.wb_sel = 2'd2; end
    if (k == K_JR) begin e.pc_we = 1'b1; e.pc_src = 2'd3; e.retire = 1'b1; end
    step(e, 1'b0, r1(), op, fn, r1(), r1());
    if (k == K_J || k == K_JAL || k == K_JR || k == K_ILL) begin
      cycles = t_cyc;
      return;
    end

    e = '0;
    case (k)
      K_ALU_R: e.alu_op = (fn == 6'h22) ? 3'd1 : (fn == 6'h2A) ? 3'd3 : 3'd0;
      K_XORI:  e.alu_op = 3'd2;
      K_BNE:   e.alu_op = 3'd1;
      default: e.alu_op = 3'd0;
    endcase
    e.alu_src_b = (k == K_ADDI || k == K_XORI || k == K_LW || k == K_SW);
    if (k == K_BNE) begin
      e.retire = 1'b1;
      e.pc_we  = !z;
      e.pc_src = z ? 2'd0 : 2'd1;
    end
    step(e, 1'b0, r1(), op, fn, z, r1());
    if (k == K_BNE) begin
      cycles = t_cyc;
      return;
    end

    if (k == K_LW || k == K_SW) begin
      for (int w = 0; w <= waits; w++) begin
        if (w == abort) begin
          do_reset_in_mem(op, fn);
          cycles = t_cyc;
          return;
        end
        e = '0; e.alu_src_b = 1'b1;
        e.mem_re = (k == K_LW); e.mem_we = (k == K_SW);
        e.retire = (k == K_SW) && (w == waits);
        step(e, 1'b0, r1(), op, fn, r1(), (w == waits));
      end
      if (k == K_SW) begin
        cycles = t_cyc;
        return;
      end
    end

    e = '0; e.reg_we = 1'b1; e.retire = 1'b1;
    e.reg_dst = (k == K_ALU_R) ? 2'd1 : 2'd0;
    e.wb_sel  = (k == K_LW) ? 2'd1 : 2'd0;
    step(e, 1'b0, r1(), op, fn, r1(), r1());
    cycles = t_cyc;
  endtask

  task automatic do_reset_in_mem(input logic [5:0] op, input logic [5:0] fn);
    step('0, 1'b1, 1'b0, op, fn, r1(), 1'b0);
  endtask

  // Directed single instruction with literal cycle-count and retire expectations
  task automatic directed(input string name, input logic [5:0] op, input logic [5:0] fn,
                          input logic z, input int waits, input int exp_cycles);
    int cyc;
    run_instr(op, fn, z, waits, -1, cyc);
    check({name, "_cycles"}, 32'(t_cyc), 32'(exp_cycles));
    check({name, "_retires"}, 32'(t_retire), 32'd1);
  endtask

  logic [5:0] leg_op [10] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h02, 6'h03, 6'h05, 6'h08, 6'h0E, 6'h23};
  logic [5:0] leg_fn [10] = '{6'h20, 6'h22, 6'h2A, 6'h08, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};

  task automatic random_instr();
    int idx, cyc;
    logic [5:0] op, fn;
    idx = $urandom_range(0, 10);
    if (idx == 10) begin
      op = 6'h2B; fn = r6();
    end else begin
      op = leg_op[idx];
      fn = (op == 6'h00) ? leg_fn[idx] : r6();
    end
    run_instr(op, fn, r1(), $urandom_range(0, 3), -1, cyc);
    check("rand_retires", 32'(t_retire), 32'd1);
  endtask

  initial begin
    int cyc;
    reset = 1'b1; run = 1'b0; op_code = '0; func = '0; alu_zero = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    do_reset();
    do_reset();
    idle_then_run(3);

    directed("add", 6'h00, 6'h20, 1'b0, 0, 4);
    directed("lw_wait3", 6'h23, 6'h00, 1'b0, 3, 8);
    check("lw_mem_re_cycles", 32'(t_mem_re), 32'd4);
    directed("bne_taken", 6'h05, 6'h00, 1'b0, 0, 3);
    directed("bne_not_taken", 6'h05, 6'h00, 1'b1, 0, 3);
    directed("jal", 6'h03, 6'h00, 1'b0, 0, 2);
    directed("j", 6'h02, 6'h11, 1'b0, 0, 2);
    directed("jr", 6'h00, 6'h08, 1'b0, 0, 2);
    directed("sw", 6'h2B, 6'h00, 1'b0, 0, 4);
    directed("lw", 6'h23, 6'h00, 1'b0, 0, 5);
    directed("sw_wait2", 6'h2B, 6'h00, 1'b0, 2, 6);
    directed("xori", 6'h0E, 6'h00, 1'b0, 0, 4);

    for (int i = 0; i < 300; i++) random_instr();

    // Five mixed instructions from a clean reset
    do_reset();
    idle_then_run(1);
    directed("mix_add", 6'h00, 6'h20, 1'b0, 0, 4);
    directed("mix_lw", 6'h23, 6'h00, 1'b0, 1, 6);
    directed("mix_bne", 6'h05, 6'h00, 1'b0, 0, 3);
    directed("mix_j", 6'h02, 6'h00, 1'b0, 0, 2);
    directed("mix_sw", 6'h2B, 6'h00, 1'b0, 0, 4);
`ifdef CPU_SEQ_PERF_CNT_EN
    check("count_after_5", instr_count, 32'd5);
`else
    check("count_tied_off", instr_count, 32'd0);
`endif

    // Reset in the second MEM cycle of a stalled SW
    run_instr(6'h2B, 6'h00, 1'b0, 3, 1, cyc);
    check("sw_abort_retires", 32'(t_retire), 32'd0);
    check("sw_abort_count", instr_count, 32'd0);
    idle_then_run(1);
    directed("after_abort", 6'h00, 6'h22, 1'b0, 0, 4);

`ifdef CPU_SEQ_PERF_CNT_EN
    do_reset();
    force dut.r_instr_count = 32'hFFFF_FFFF;
    m_cnt = 32'hFFFF_FFFF;
    step('0, 1'b0, 1'b0, r6(), r6(), r1(), r1());
    release dut.r_instr_count;
    step('0, 1'b0, 1'b1, r6(), r6(), r1(), r1());
    directed("wrap_j", 6'h02, 6'h00, 1'b0, 0, 2);
    check("count_wrap", instr_count, 32'd0);
`endif

    // Illegal opcode traps into HALT until reset
    do_reset();
    idle_then_run(0);
    run_instr(6'h3F, 6'h00, 1'b0, 0, -1, cyc);
    check("illegal_retires", 32'(t_retire), 32'd0);
    for (int i = 0; i < 10; i++) begin
      ctl_t h;
      h = '0; h.halted = 1'b1;
      step(h, 1'b0, 1'b1, r6(), r6(), r1(), r1());
    end
    check("halted_stays", 32'(halted), 32'd1);
    do_reset();
    check("halted_after_reset", 32'(halted), 32'd0);
    idle_then_run(2);
    directed("after_halt", 6'h08, 6'h00, 1'b0, 0, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
